// File: rtl/data_buffer_pkg.sv
// Shared constants for the data_buffer FIFO slice.
//   DB_WIDTH  : default data byte width in bits
//   DB_DEPTH  : default entry count (power of two, 4..128)
//   DB_PTR_W  : default pointer width, index bits plus one wrap bit
package data_buffer_pkg;

  localparam int unsigned DB_WIDTH = 8;
  localparam int unsigned DB_DEPTH = 64;
  localparam int unsigned DB_PTR_W = $clog2(DB_DEPTH) + 1;

endpackage

// File: rtl/data_buffer_fifo_ptr.sv
// fifo_ptr: enabled, synchronously flushable pointer register.
// The top bit is the wrap bit; a plain binary increment wraps the index
// field from all-ones to zero while toggling the wrap bit.
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset, pointer to 0
//   flush : synchronous clear, priority over inc
//   inc   : advance pointer by one
//   ptr   : current pointer value
module fifo_ptr
  import data_buffer_pkg::*;
#(
  parameter int unsigned PTR_W = DB_PTR_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/data_buffer.sv
// data_buffer: first-word fall-through circular FIFO with sticky error flags.
//   clk              : clock, rising edge
//   n_rst            : asynchronous active-low reset
//   flush            : synchronous clear of pointers and error flags
//   load_buf         : push data_in this cycle
//   data_in          : byte to push
//   get_data         : pop head entry this cycle
//   data_out         : head entry, zero when empty
//   buffer_occupancy : entries held, 0..DEPTH
//   empty / full     : occupancy == 0 / occupancy == DEPTH
//   overflow_err     : sticky, push while full without a pop
//   underflow_err    : sticky, pop while empty
module data_buffer
  import data_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DB_WIDTH,
  parameter int unsigned DEPTH = DB_DEPTH
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     load_buf,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     get_data,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   buffer_occupancy,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occ;

  logic push_ok;
  logic pop_ok;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Wrap-bit pointers make the modular difference the exact occupancy,
  // distinguishing full (DEPTH) from empty (0).
  assign occ   = wr_ptr - rd_ptr;
  assign empty = (occ == '0);
  assign full  = (occ == PTR_W'(DEPTH));

  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      // A full buffer still takes a push when the head leaves the same cycle.
      push_ok = load_buf && (!full || get_data);
      pop_ok  = get_data && !empty;
      if (load_buf && full && !get_data) begin
        ovf_d = 1'b1;
      end
      if (get_data && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (flush),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (flush),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // Storage is not reset; pointer reset alone makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr[IDX_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign data_out         = empty ? '0 : mem_q[rd_ptr[IDX_W-1:0]];
  assign buffer_occupancy = occ;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: tb/tb_data_buffer.sv
module tb_data_buffer;

  localparam int unsigned W = 8;
  localparam int unsigned D = 64;

  logic         clk;
  logic         n_rst;
  logic         flush;
  logic         load_buf;
  logic [W-1:0] data_in;
  logic         get_data;
  logic [W-1:0] data_out;
  logic [6:0]   buffer_occupancy;
  logic         empty;
  logic         full;
  logic         overflow_err;
  logic         underflow_err;

  data_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .flush            (flush),
    .load_buf         (load_buf),
    .data_in          (data_in),
    .get_data         (get_data),
    .data_out         (data_out),
    .buffer_occupancy (buffer_occupancy),
    .empty            (empty),
    .full             (full),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: a queue of held bytes plus two sticky flags.
  logic [W-1:0] mq[$];
  logic         m_ovf;
  logic         m_unf;

  typedef struct {
    logic         fl;
    logic         ld;
    logic [W-1:0] din;
    logic         gd;
    int unsigned  occ;
    logic [W-1:0] dout;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t tbl[10];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic fl, input logic ld, input logic [W-1:0] din,
                            input logic gd);
    int unsigned n;
    n = mq.size();
    if (fl) begin
      model_reset();
    end else begin
      if (gd && n == 0) m_unf = 1'b1;
      if (ld && n == D && !gd) m_ovf = 1'b1;
      if (gd && n > 0) void'(mq.pop_front());
      if (ld && !(n == D && !gd)) mq.push_back(din);
    end
  endtask

  // Drive one cycle, let the edge happen, update the model with the same inputs.
  task automatic step(input logic fl, input logic ld, input logic [W-1:0] din, input logic gd);
    flush    = fl;
    load_buf = ld;
    data_in  = din;
    get_data = gd;
    @(posedge clk);
    #1;
    model_step(fl, ld, din, gd);
    flush    = 1'b0;
    load_buf = 1'b0;
    get_data = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] exp_dout;
    exp_dout = (mq.size() > 0) ? mq[0] : '0;
    cmp({tag, ".occ"},   32'(buffer_occupancy), 32'(mq.size()));
    cmp({tag, ".empty"}, 32'(empty),            32'(mq.size() == 0));
    cmp({tag, ".full"},  32'(full),             32'(mq.size() == D));
    cmp({tag, ".dout"},  32'(data_out),         32'(exp_dout));
    cmp({tag, ".ovf"},   32'(overflow_err),     32'(m_ovf));
    cmp({tag, ".unf"},   32'(underflow_err),    32'(m_unf));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst    = 1'b0;
    flush    = 1'b0;
    load_buf = 1'b0;
    data_in  = '0;
    get_data = 1'b0;
    model_reset();

    #12;
    cmp("rst.occ",   32'(buffer_occupancy), 32'd0);
    cmp("rst.empty", 32'(empty),            32'd1);
    cmp("rst.full",  32'(full),             32'd0);
    cmp("rst.dout",  32'(data_out),         32'd0);
    cmp("rst.ovf",   32'(overflow_err),     32'd0);
    cmp("rst.unf",   32'(underflow_err),    32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Directed table: basic pushes/pops, push+pop on empty, flush priority.
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 2, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 1, 8'h11, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h22, 1'b1, 1, 8'h22, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'hEE, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].fl, tbl[i].ld, tbl[i].din, tbl[i].gd);
      cmp($sformatf("tbl%0d.occ", i),  32'(buffer_occupancy), 32'(tbl[i].occ));
      cmp($sformatf("tbl%0d.dout", i), 32'(data_out),         32'(tbl[i].dout));
      cmp($sformatf("tbl%0d.ovf", i),  32'(overflow_err),     32'(tbl[i].ovf));
      cmp($sformatf("tbl%0d.unf", i),  32'(underflow_err),    32'(tbl[i].unf));
      cmp($sformatf("tbl%0d.empty", i), 32'(empty),           32'(tbl[i].occ == 0));
    end

    // Fill to full, overflow drop, drain in order.
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    cmp("fill.full", 32'(full),             32'd1);
    cmp("fill.occ",  32'(buffer_occupancy), 32'd64);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    cmp("ovf.occ",  32'(buffer_occupancy), 32'd64);
    cmp("ovf.flag", 32'(overflow_err),     32'd1);
    for (int i = 0; i < 64; i++) begin
      cmp($sformatf("drain%0d", i), 32'(data_out), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    cmp("drain.empty", 32'(empty),        32'd1);
    cmp("drain.ovf",   32'(overflow_err), 32'd1);
    cmp("drain.dout",  32'(data_out),     32'd0);

    // Push and pop on a full buffer.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    cmp("fpp.head", 32'(data_out), 32'h00);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    cmp("fpp.occ",  32'(buffer_occupancy), 32'd64);
    cmp("fpp.ovf",  32'(overflow_err),     32'd0);
    cmp("fpp.next", 32'(data_out),         32'h01);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    cmp("fpp.last", 32'(data_out),         32'h77);
    cmp("fpp.occ1", 32'(buffer_occupancy), 32'd1);

    // Flush with both strobes, then a push must land at the reset head.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(8'h40 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check_model("preflush");
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    check_model("flush");
    step(1'b0, 1'b1, 8'h99, 1'b0);
    check_model("postflush");

    // Randomized traffic against the queue model, crossing pointer wrap.
    for (int i = 0; i < 500; i++) begin
      logic fl, ld, gd;
      fl = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 99) < 55);
      gd = ($urandom_range(0, 99) < 45);
      step(fl, ld, W'($urandom), gd);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a clock period.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_model("arst");
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    check_model("arst.push");
    cmp("arst.dout", 32'(data_out), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_buffer.md
DATA_BUFFER -- requirements
Module: data_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits.
REQ-002 Parameter DEPTH, default 64, entry count, power of two, 4..128.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of contents and error flags (same flush that clears the load counter).
REQ-006 load_buf  input  1  write strobe: push data_in this cycle.
REQ-007 data_in  input  WIDTH  byte to push.
REQ-008 get_data  input  1  read strobe: pop head entry this cycle.
REQ-009 data_out  output  WIDTH  head entry, first-word fall-through.
REQ-010 buffer_occupancy  output  clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 overflow_err  output  1  sticky: push attempted while full and not popping.
REQ-014 underflow_err  output  1  sticky: pop attempted while empty.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH circular array with read and write pointers of clog2(DEPTH)+1 bits (index plus wrap bit).
REQ-016 Occupancy SHALL equal (wr_ptr - rd_ptr) modulo 2^(clog2(DEPTH)+1), registered-pointer derived, no separate counter.
REQ-017 A push SHALL write data_in at wr_ptr and increment wr_ptr at the same edge; data visible on data_out the next cycle if buffer was empty.
REQ-018 data_out SHALL combinationally show mem[rd_ptr index] when not empty, and all-zero when empty.
REQ-019 A pop SHALL increment rd_ptr; the next entry appears on data_out the following cycle.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 in the index field while toggling the wrap bit.
REQ-021 Push while full with no pop SHALL be dropped: no write, no pointer change, overflow_err set next edge.
REQ-022 Pop while empty SHALL be ignored: no pointer change, underflow_err set next edge.
REQ-023 Simultaneous push and pop when full SHALL both be accepted; occupancy stays DEPTH.
REQ-024 Simultaneous push and pop when empty SHALL accept the push only and set underflow_err; occupancy becomes 1.
REQ-025 Simultaneous push and pop otherwise SHALL both be accepted; occupancy unchanged.
REQ-026 flush SHALL take priority over load_buf and get_data: pointers to 0, both error flags to 0, no write that cycle.
REQ-027 Error flags SHALL remain set until flush or reset.
REQ-028 Memory contents SHALL not be cleared by flush; only pointers reset.

Reset
REQ-029 n_rst low SHALL immediately force pointers to 0, buffer_occupancy 0, empty 1, full 0, both error flags 0, data_out 0.
REQ-030 Reset asserted mid-operation SHALL discard all held entries; first push after release lands at index 0.
REQ-031 Memory array SHALL not require reset.

Structure
REQ-032 A shared package data_buffer_pkg SHALL hold default WIDTH, DEPTH and derived pointer width constant.
REQ-033 One sub-module fifo_ptr SHALL implement an enabled, flushable wrap-bit pointer register, instantiated twice (read, write).
REQ-034 Full, empty and occupancy SHALL be combinational from the two pointers.

Verification
REQ-035 Reset, push 0xA5, 0x3C -> occupancy 2, data_out 0xA5; pop -> data_out 0x3C, occupancy 1.
REQ-036 Push 64 bytes 0x00..0x3F -> full 1, occupancy 64; push 0xFF -> dropped, overflow_err 1; pop 64 -> values 0x00..0x3F in order, empty 1.
REQ-037 Fill to 64, then push 0x77 with pop same cycle -> occupancy 64, popped 0x00, 0x77 last out after 63 more pops.
REQ-038 Empty, push 0x11 with pop same cycle -> occupancy 1, data_out 0x11, underflow_err 1.
REQ-039 Push 10 bytes, flush with load_buf and get_data high -> occupancy 0, empty 1, errors 0, no write.
REQ-040 Push 100 / pop 100 interleaved across pointer wrap, then assert n_rst asynchronously mid-clock -> outputs at reset values before next edge.
